// File: rtl/div_iter_p_pkg.sv
// Shared encodings, state type and word constants for the iterative divider.
package div_iter_p_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_CALC = 4'b0010,
        ST_FIN  = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    localparam int MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] ALL_ONES_W = {MAX_XLEN{1'b1}};
    localparam logic [MAX_XLEN-1:0] ZERO_W     = {MAX_XLEN{1'b0}};

    // DIV and REM are the signed forms (funct3 bit 0 clear).
    function automatic logic op_is_signed(input logic [2:0] op);
        return op[2] & ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/div_iter_p_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_iter_p_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    import div_iter_p_pkg::*;

    logic               req_valid_i;
    logic               req_ready_o;
    logic [2:0]         op_i;
    logic [XLEN-1:0]    dividend_i;
    logic [XLEN-1:0]    divisor_i;
    logic [RADDR_W-1:0] reg_waddr_i;
    logic               flush_i;
    logic               resp_valid_o;
    logic               resp_ready_i;
    logic [XLEN-1:0]    result_o;
    logic [RADDR_W-1:0] reg_waddr_o;
    logic               busy_o;

    modport slave (
        input  req_valid_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o, reg_waddr_o, busy_o
    );

    modport master (
        output req_valid_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o, reg_waddr_o, busy_o
    );

endinterface

// File: rtl/div_iter_p_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            quot_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // rem_in < divisor always holds, so the XLEN+1-bit difference's top bit is a clean borrow.
    always_comb begin
        shifted_s = {rem_in, quot_msb};
        diff_s    = shifted_s - {1'b0, divisor};
        q_bit     = ~diff_s[XLEN];
        if (q_bit) begin
            rem_out = diff_s[XLEN-1:0];
        end else begin
            rem_out = shifted_s[XLEN-1:0];
        end
    end

endmodule

// File: rtl/div_iter_p.sv
// Iterative restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU with valid/ready handshake and flush.
module div_iter_p
    import div_iter_p_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int STEPS   = 1,
    parameter int RADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    div_iter_p_if.slave bus
);

    localparam int NCYC  = XLEN / STEPS;
    localparam int CNT_W = $clog2(NCYC + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NCYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  ONES_X   = ALL_ONES_W[XLEN-1:0];
    localparam logic [XLEN-1:0]  ZERO_X   = ZERO_W[XLEN-1:0];
    localparam logic [XLEN-1:0]  MIN_X    = {1'b1, ZERO_W[XLEN-2:0]};

    state_e             state_q, state_d;
    logic               is_rem_q, is_rem_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    quot_q, quot_d;
    logic [XLEN-1:0]    dvsr_q, dvsr_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic [RADDR_W-1:0] waddr_out_q, waddr_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               signed_s, rem_op_s, dvd_neg_s, dvs_neg_s;
    logic               div_zero_s, overflow_s, accept_s;
    logic [XLEN-1:0]    abs_dvd_s, abs_dvs_s, special_res_s;

    logic [XLEN-1:0]    rem_chain_s  [STEPS+1];
    logic [XLEN-1:0]    quot_chain_s [STEPS+1];
    logic [STEPS-1:0]   qbit_s;

    // Decode the incoming request: magnitudes, sign flags and the two special cases.
    always_comb begin
        signed_s  = op_is_signed(bus.op_i);
        rem_op_s  = op_is_rem(bus.op_i);
        dvd_neg_s = signed_s & bus.dividend_i[XLEN-1];
        dvs_neg_s = signed_s & bus.divisor_i[XLEN-1];
        if (dvd_neg_s) begin
            abs_dvd_s = ZERO_X - bus.dividend_i;
        end else begin
            abs_dvd_s = bus.dividend_i;
        end
        if (dvs_neg_s) begin
            abs_dvs_s = ZERO_X - bus.divisor_i;
        end else begin
            abs_dvs_s = bus.divisor_i;
        end
        div_zero_s = (bus.divisor_i == ZERO_X);
        overflow_s = signed_s & (bus.dividend_i == MIN_X) & (bus.divisor_i == ONES_X);
        if (div_zero_s) begin
            special_res_s = rem_op_s ? bus.dividend_i : ONES_X;
        end else if (overflow_s) begin
            special_res_s = rem_op_s ? ZERO_X : bus.dividend_i;
        end else begin
            special_res_s = ZERO_X;
        end
        accept_s = bus.req_valid_i & (state_q == ST_IDLE) & ~bus.flush_i;
    end

    assign rem_chain_s[0]  = rem_q;
    assign quot_chain_s[0] = quot_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in   (rem_chain_s[g]),
            .quot_msb (quot_chain_s[g][XLEN-1]),
            .divisor  (dvsr_q),
            .rem_out  (rem_chain_s[g+1]),
            .q_bit    (qbit_s[g])
        );
        assign quot_chain_s[g+1] = {quot_chain_s[g][XLEN-2:0], qbit_s[g]};
    end

    // Next-state and datapath update; flush overrides every state including the DONE handshake.
    always_comb begin
        state_d     = state_q;
        is_rem_d    = is_rem_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        dvsr_d      = dvsr_q;
        result_d    = result_q;
        waddr_d     = waddr_q;
        waddr_out_d = waddr_out_q;
        cnt_d       = cnt_q;
        if (bus.flush_i) begin
            state_d     = ST_IDLE;
            result_d    = ZERO_X;
            waddr_out_d = {RADDR_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        is_rem_d   = rem_op_s;
                        waddr_d    = bus.reg_waddr_i;
                        neg_quot_d = ~rem_op_s & (dvd_neg_s ^ dvs_neg_s);
                        neg_rem_d  = rem_op_s & dvd_neg_s;
                        dvsr_d     = abs_dvs_s;
                        if (div_zero_s || overflow_s) begin
                            result_d    = special_res_s;
                            waddr_out_d = bus.reg_waddr_i;
                            state_d     = ST_DONE;
                        end else begin
                            rem_d   = ZERO_X;
                            quot_d  = abs_dvd_s;
                            cnt_d   = CNT_INIT;
                            state_d = ST_CALC;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_d  = rem_chain_s[STEPS];
                    quot_d = quot_chain_s[STEPS];
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_FIN: begin
                    if (is_rem_q) begin
                        result_d = neg_rem_q ? (ZERO_X - rem_q) : rem_q;
                    end else begin
                        result_d = neg_quot_q ? (ZERO_X - quot_q) : quot_q;
                    end
                    waddr_out_d = waddr_q;
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.resp_ready_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            is_rem_q    <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            rem_q       <= {XLEN{1'b0}};
            quot_q      <= {XLEN{1'b0}};
            dvsr_q      <= {XLEN{1'b0}};
            result_q    <= {XLEN{1'b0}};
            waddr_q     <= {RADDR_W{1'b0}};
            waddr_out_q <= {RADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            is_rem_q    <= is_rem_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            dvsr_q      <= dvsr_d;
            result_q    <= result_d;
            waddr_q     <= waddr_d;
            waddr_out_q <= waddr_out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready_o  = (state_q == ST_IDLE);
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.resp_valid_o = (state_q == ST_DONE);
    assign bus.result_o     = result_q;
    assign bus.reg_waddr_o  = waddr_out_q;

endmodule

// File: tb/tb_div_iter_p.sv
// Directed bench for div_iter_p in three configurations (32/1, 32/2, 64/4).
module tb_div_iter_p;
    import div_iter_p_pkg::*;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONE64 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_iter_p_if #(.XLEN(32), .RADDR_W(5)) ifa ();
    div_iter_p_if #(.XLEN(32), .RADDR_W(5)) ifb ();
    div_iter_p_if #(.XLEN(64), .RADDR_W(5)) ifc ();

    div_iter_p #(.XLEN(32), .STEPS(1), .RADDR_W(5)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    div_iter_p #(.XLEN(32), .STEPS(2), .RADDR_W(5)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    div_iter_p #(.XLEN(64), .STEPS(4), .RADDR_W(5)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    logic        rv32 [2];
    logic        rr32 [2];
    logic        bz32 [2];
    logic [31:0] res32 [2];
    logic [4:0]  wo32 [2];

    assign rv32[0] = ifa.resp_valid_o;  assign rv32[1] = ifb.resp_valid_o;
    assign rr32[0] = ifa.req_ready_o;   assign rr32[1] = ifb.req_ready_o;
    assign bz32[0] = ifa.busy_o;        assign bz32[1] = ifb.busy_o;
    assign res32[0] = ifa.result_o;     assign res32[1] = ifb.result_o;
    assign wo32[0] = ifa.reg_waddr_o;   assign wo32[1] = ifb.reg_waddr_o;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive32(input int k, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        if (k == 0) begin
            ifa.req_valid_i = v; ifa.op_i = op; ifa.dividend_i = a; ifa.divisor_i = b; ifa.reg_waddr_i = wa;
        end else begin
            ifb.req_valid_i = v; ifb.op_i = op; ifb.dividend_i = a; ifb.divisor_i = b; ifb.reg_waddr_i = wa;
        end
    endtask

    task automatic ctl32(input int k, input logic fl, input logic rr);
        if (k == 0) begin
            ifa.flush_i = fl; ifa.resp_ready_i = rr;
        end else begin
            ifb.flush_i = fl; ifb.resp_ready_i = rr;
        end
    endtask

    // Issue one request, measure latency, optionally stall the response, then hand it off.
    task automatic run32(input int k, input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
        int lat;
        drive32(k, 1'b1, op, a, b, wa);
        @(posedge clk); #1;
        drive32(k, 1'b0, op, a, b, wa);
        lat = 1;
        while (!rv32[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/res"}, {32'd0, res32[k]}, {32'd0, exp_res});
        chk({tag, "/wa"}, {59'd0, wo32[k]}, {59'd0, wa});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_v"}, {63'd0, rv32[k]}, 64'd1);
            chk({tag, "/hold_res"}, {32'd0, res32[k]}, {32'd0, exp_res});
            chk({tag, "/hold_wa"}, {59'd0, wo32[k]}, {59'd0, wa});
            chk({tag, "/hold_rdy"}, {63'd0, rr32[k]}, 64'd0);
        end
        ctl32(k, 1'b0, 1'b1);
        @(posedge clk); #1;
        ctl32(k, 1'b0, 1'b0);
        chk({tag, "/post_v"}, {63'd0, rv32[k]}, 64'd0);
        chk({tag, "/post_rdy"}, {63'd0, rr32[k]}, 64'd1);
    endtask

    function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        logic [63:0] q, r;
        sa = a;
        sb = b;
        if (b == 64'd0) begin
            q = ONE64; r = a;
        end else if (!op[0] && a == MIN64 && b == ONE64) begin
            q = a; r = 64'd0;
        end else if (!op[0]) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
        int lat;
        ifc.req_valid_i = 1'b1; ifc.op_i = op; ifc.dividend_i = a; ifc.divisor_i = b; ifc.reg_waddr_i = 5'd17;
        @(posedge clk); #1;
        ifc.req_valid_i = 1'b0;
        lat = 1;
        while (!ifc.resp_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("sw64/lat", 64'(lat), 64'(exp_lat));
        chk("sw64/res", ifc.result_o, exp_res);
        ifc.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        ifc.resp_ready_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [63:0] a, b, e;
        logic        seen;
        bit          special;

        drive32(0, 1'b0, INST_DIV, 32'd0, 32'd0, 5'd0);
        drive32(1, 1'b0, INST_DIV, 32'd0, 32'd0, 5'd0);
        ctl32(0, 1'b0, 1'b0);
        ctl32(1, 1'b0, 1'b0);
        ifc.req_valid_i = 1'b0; ifc.op_i = INST_DIV; ifc.dividend_i = 64'd0; ifc.divisor_i = 64'd0;
        ifc.reg_waddr_i = 5'd0; ifc.flush_i = 1'b0; ifc.resp_ready_i = 1'b0;

        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst/rdy", {63'd0, rr32[k]}, 64'd1);
            chk("rst/busy", {63'd0, bz32[k]}, 64'd0);
            chk("rst/valid", {63'd0, rv32[k]}, 64'd0);
            chk("rst/res", {32'd0, res32[k]}, 64'd0);
            chk("rst/wa", {59'd0, wo32[k]}, 64'd0);
        end
        chk("rst/c_rdy", {63'd0, ifc.req_ready_o}, 64'd1);
        chk("rst/c_res", ifc.result_o, 64'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // 32-bit, one bit per cycle
        run32(0, "div20_m3",  INST_DIV,  32'd20,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFA, 34, 0);
        run32(0, "rem20_m3",  INST_REM,  32'd20,          32'hFFFF_FFFD, 5'd6,  32'h0000_0002, 34, 0);
        run32(0, "divm20_3",  INST_DIV,  32'hFFFF_FFEC,   32'd3,         5'd7,  32'hFFFF_FFFA, 34, 0);
        run32(0, "remm20_3",  INST_REM,  32'hFFFF_FFEC,   32'd3,         5'd8,  32'hFFFF_FFFE, 34, 0);
        run32(0, "div_ovf",   INST_DIV,  32'h8000_0000,   32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1,  0);
        run32(0, "rem_ovf",   INST_REM,  32'h8000_0000,   32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1,  0);
        run32(0, "div7_0",    INST_DIV,  32'd7,           32'd0,         5'd11, 32'hFFFF_FFFF, 1,  0);
        run32(0, "rem7_0",    INST_REM,  32'd7,           32'd0,         5'd12, 32'h0000_0007, 1,  0);
        run32(0, "divu7_0",   INST_DIVU, 32'd7,           32'd0,         5'd13, 32'hFFFF_FFFF, 1,  0);
        run32(0, "remu_min0", INST_REMU, 32'h8000_0000,   32'd0,         5'd14, 32'h8000_0000, 1,  0);

        // 32-bit, two bits per cycle, including a stalled response
        run32(1, "divu_ff_10", INST_DIVU, 32'hFFFF_FFFF, 32'h10,        5'd20, 32'h0FFF_FFFF, 18, 0);
        run32(1, "remu_ff_10", INST_REMU, 32'hFFFF_FFFF, 32'h10,        5'd21, 32'h0000_000F, 18, 5);
        run32(1, "divu_min_1", INST_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 18, 0);
        run32(1, "remu_min_1", INST_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h8000_0000, 18, 0);
        run32(1, "div100_7",   INST_DIV,  32'd100,       32'd7,         5'd24, 32'd14,        18, 0);
        run32(1, "remm100_7",  INST_REM,  32'hFFFF_FF9C, 32'd7,         5'd25, 32'hFFFF_FFFE, 18, 0);

        // flush partway through CALC
        drive32(0, 1'b1, INST_DIV, 32'd100, 32'd7, 5'd9);
        @(posedge clk); #1;
        drive32(0, 1'b0, INST_DIV, 32'd100, 32'd7, 5'd9);
        repeat (9) @(posedge clk);
        #1;
        chk("flush/busy_before", {63'd0, bz32[0]}, 64'd1);
        ctl32(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        ctl32(0, 1'b0, 1'b0);
        chk("flush/busy", {63'd0, bz32[0]}, 64'd0);
        chk("flush/valid", {63'd0, rv32[0]}, 64'd0);
        chk("flush/res", {32'd0, res32[0]}, 64'd0);
        chk("flush/wa", {59'd0, wo32[0]}, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (rv32[0]) seen = 1'b1;
        end
        chk("flush/no_resp", {63'd0, seen}, 64'd0);

        // flush together with a request in IDLE
        drive32(0, 1'b1, INST_DIVU, 32'd9, 32'd3, 5'd4);
        ctl32(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive32(0, 1'b0, INST_DIVU, 32'd9, 32'd3, 5'd4);
        ctl32(0, 1'b0, 1'b0);
        chk("flushreq/busy", {63'd0, bz32[0]}, 64'd0);
        chk("flushreq/rdy", {63'd0, rr32[0]}, 64'd1);
        @(posedge clk); #1;
        chk("flushreq/busy2", {63'd0, bz32[0]}, 64'd0);

        // asynchronous reset in the middle of CALC
        run32(0, "divu100_7", INST_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34, 0);
        drive32(0, 1'b1, INST_DIV, 32'd20, 32'hFFFF_FFFD, 5'd2);
        @(posedge clk); #1;
        drive32(0, 1'b0, INST_DIV, 32'd20, 32'hFFFF_FFFD, 5'd2);
        repeat (5) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        chk("arst/busy", {63'd0, bz32[0]}, 64'd0);
        chk("arst/valid", {63'd0, rv32[0]}, 64'd0);
        chk("arst/res_b", {32'd0, res32[1]}, 64'd0);
        chk("arst/wa_b", {59'd0, wo32[1]}, 64'd0);
        chk("arst/rdy", {63'd0, rr32[0]}, 64'd1);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        run32(0, "after_rst", INST_DIV, 32'd20, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFA, 34, 0);

        // 64-bit, four bits per cycle: mixed-sign sweep against the reference model
        for (int i = 0; i < 1000; i++) begin
            op = INST_DIV | 3'(i % 4);
            a = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) a = 64'd0 - a;
            if ($urandom_range(0, 1) == 1) b = 64'd0 - b;
            if (i % 64 == 5) b = 64'd0;
            if (i % 64 == 9) begin
                a = MIN64;
                b = ONE64;
            end
            e = ref64(op, a, b);
            special = (b == 64'd0) || (!op[0] && a == MIN64 && b == ONE64);
            run64(op, a, b, e, special ? 1 : 18);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_iter_p.md
Name: div_iter_p

Overview:
- Parameterised iterative restoring divider for the RV32M/RV64M DIV/DIVU/REM/REMU instructions, sitting beside the EX stage.
- Generalises the existing divider in four ways:
  - configurable operand width XLEN;
  - configurable quotient bits retired per cycle;
  - a valid/ready request/response handshake instead of a held start level;
  - a flush input, plus explicit signed-overflow handling.
- Results are held until EX accepts them.

Parameters:
XLEN, 32, operand/result width (32 or 64)
STEPS, 1, quotient bits per CALC cycle (1, 2 or 4; must divide XLEN)
RADDR_W, 5, destination register address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  divider can accept a request
op_i  in  3  funct3 (DIV=100, DIVU=101, REM=110, REMU=111)
dividend_i  in  XLEN  rs1 value
divisor_i  in  XLEN  rs2 value
reg_waddr_i  in  RADDR_W  destination register
flush_i  in  1  kill in-flight operation (pipeline flush)
resp_valid_o  out  1  result valid
resp_ready_i  in  1  EX consumes the result
result_o  out  XLEN  quotient or remainder per op
reg_waddr_o  out  RADDR_W  destination of result_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst low, async):
  - state=IDLE;
  - result_o=0, reg_waddr_o=0, resp_valid_o=0, busy_o=0;
  - all internal registers 0.
- req_ready_o = (state==IDLE), combinational. It therefore reads 1 out of reset.
- Accept condition: req_valid_i & req_ready_o & !flush_i. If flush_i is high in that cycle, nothing is accepted.
- States: IDLE -> CALC -> FIN -> DONE -> IDLE. Special cases go IDLE -> DONE.
- IDLE, on accept:
  - latch op and reg_waddr;
  - latch |dividend| and |divisor| (two's-complement negation only for signed ops with MSB set);
  - latch the negate flags:
    - quotient negated when the signs differ (DIV only);
    - remainder negated when the dividend is negative (REM only).
- Special cases, decided at accept; the next state is DONE with a pre-set result:
  - divisor==0:
    - DIV/DIVU result = all ones;
    - REM/REMU result = dividend_i unchanged.
  - Signed overflow (DIV/REM, dividend = 1 followed by XLEN-1 zeros, divisor = all ones):
    - DIV result = dividend_i;
    - REM result = 0.
- Normal path: remainder register = 0, quotient shift register = |dividend|, count = XLEN/STEPS, then CALC.
- CALC, each cycle: STEPS chained restoring steps.
  - Shift remainder left, injecting the quotient MSB.
  - Compare against |divisor| using XLEN+1-bit subtraction, so no carry is lost at XLEN=64.
  - Shift in quotient bit = (rem >= divisor); subtract if set.
  - count decrements. On the cycle count==1, next state is FIN.
- FIN: apply the negate flag to the selected result (quotient for DIV/DIVU, remainder for REM/REMU), register it into result_o, go to DONE.
- DONE:
  - resp_valid_o=1; result_o and reg_waddr_o held stable.
  - Stays in DONE while !resp_ready_i.
  - On resp_ready_i: IDLE next cycle, resp_valid_o=0.
- Latency (accept edge to resp_valid_o high):
  - normal: XLEN/STEPS+2 cycles (34 for 32/1; 18 for 32/2);
  - special cases: 1 cycle.
- A new request can be accepted in the cycle after the response handshake; there is no back-to-back accept in the DONE cycle.
- flush_i high in any state: next state IDLE; resp_valid_o=0, busy_o=0; result_o and reg_waddr_o cleared to 0. flush_i has priority over the response handshake.
- Remainder sign always equals the dividend sign; quotient truncates toward zero (RISC-V M semantics).

Decomposition:
- Shared package (defines file):
  - op encodings INST_DIV/DIVU/REM/REMU;
  - state encodings (one-hot, 4 bits);
  - the all-ones and zero-word constants.
- Sub-module div_step: one combinational restoring step (rem_in, quot_msb, divisor -> rem_out, q_bit). It is instantiated STEPS times in a generate chain.

Test Plan (XLEN=32 unless stated):
- DIV 20 / -3 (STEPS=1) -> after 34 cycles resp_valid_o=1, result_o=0xFFFFFFFA (-6); REM same operands -> 0x00000002.
- DIVU 0xFFFFFFFF / 0x10 (STEPS=2) -> 18-cycle latency, result_o=0x0FFFFFFF; REMU -> 0x0000000F.
- DIV 0x80000000 / 0xFFFFFFFF -> 1 cycle later result_o=0x80000000; REM -> 0; divisor 0: DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7.
- Backpressure: hold resp_ready_i=0 for 5 cycles after resp_valid_o -> result_o, reg_waddr_o, resp_valid_o stable and req_ready_o=0; then ready 1 -> IDLE next cycle, req_ready_o=1.
- Flush mid-CALC (cycle 10) -> next cycle busy_o=0, resp_valid_o never asserts; flush_i together with req_valid_i in IDLE -> no accept, busy_o stays 0.
- Async reset asserted mid-CALC without a clock edge -> busy_o=0, resp_valid_o=0, result_o=0 immediately; XLEN=64, STEPS=4 random signed/unsigned sweep of 1000 ops against a reference model.
